systolic_feeder: RTL



---
 rtl/systolic_feeder.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/systolic_feeder.sv
// Operand feeder for the 4x4 systolic array: buffers matrices A and B, then streams skewed wavefronts.
// Optional SYSTOLIC_FEEDER_ERR_EN adds a sticky err flag for requests made while busy.
module systolic_feeder #(
   parameter int unsigned DW           = 16,
   parameter int unsigned DRAIN_CYCLES = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic          wr_sel,
   input  logic [3:0]    wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          start,
   output logic          busy,
   output logic          arr_rst,
   output logic [DW-1:0] out_west0,
   output logic [DW-1:0] out_west4,
   output logic [DW-1:0] out_west8,
   output logic [DW-1:0] out_west12,
   output logic [DW-1:0] out_north0,
   output logic [DW-1:0] out_north1,
   output logic [DW-1:0] out_north2,
   output logic [DW-1:0] out_north3,
`ifdef SYSTOLIC_FEEDER_ERR_EN
   input  logic          err_clr,
   output logic          err,
`endif
   output logic          done
);

   localparam int unsigned FeedLen = 7;
   localparam int unsigned CntMax  = (DRAIN_CYCLES > FeedLen) ? DRAIN_CYCLES : FeedLen;
   localparam int unsigned CW      = $clog2(CntMax + 1);

   typedef enum logic [2:0] {StIdle, StClear, StFeed, StDrain, StFin} state_e;

   state_e        state_q;
   logic [CW-1:0] cnt_q;
   logic [DW-1:0] a_q [16];
   logic [DW-1:0] b_q [16];
   logic [DW-1:0] west_q [4];
   logic [DW-1:0] north_q [4];
   logic [DW-1:0] west_d [4];
   logic [DW-1:0] north_d [4];

   logic          feed_en;
   logic [2:0]    wave_t;
   logic [2:0]    d_off;
   logic [3:0]    a_idx;
   logic [3:0]    b_idx;
   logic          in_band;

   // Wavefront for the coming cycle: t=0 is loaded while leaving CLEAR.
   always_comb begin
      feed_en = (state_q == StClear) ||
                ((state_q == StFeed) && (cnt_q != CW'(FeedLen - 1)));
      wave_t  = (state_q == StClear) ? 3'd0 : 3'(cnt_q + 1'b1);
      d_off   = '0;
      a_idx   = '0;
      b_idx   = '0;
      in_band = 1'b0;
      for (int i = 0; i < 4; i++) begin
         d_off      = wave_t - 3'(i);
         in_band    = feed_en && (wave_t >= 3'(i)) && (d_off <= 3'd3);
         a_idx      = {2'(i), d_off[1:0]};
         b_idx      = {d_off[1:0], 2'(i)};
         west_d[i]  = in_band ? a_q[a_idx] : '0;
         north_d[i] = in_band ? b_q[b_idx] : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         busy    <= 1'b0;
         arr_rst <= 1'b0;
         done    <= 1'b0;
         for (int k = 0; k < 16; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
         end
         for (int k = 0; k < 4; k++) begin
            west_q[k]  <= '0;
            north_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            west_q[k]  <= west_d[k];
            north_q[k] <= north_d[k];
         end
         case (state_q)
            StIdle: begin
               if (wr_en) begin
                  if (wr_sel) b_q[wr_addr] <= wr_data;
                  else        a_q[wr_addr] <= wr_data;
               end
               if (start) begin
                  state_q <= StClear;
                  busy    <= 1'b1;
                  arr_rst <= 1'b1;
               end
            end
            StClear: begin
               state_q <= StFeed;
               arr_rst <= 1'b0;
               cnt_q   <= '0;
            end
            StFeed: begin
               if (cnt_q == CW'(FeedLen - 1)) begin
                  cnt_q <= '0;
                  if (DRAIN_CYCLES == 0) begin
                     state_q <= StFin;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end else begin
                     state_q <= StDrain;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StDrain: begin
               if (cnt_q == CW'(DRAIN_CYCLES - 1)) begin
                  state_q <= StFin;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StFin: begin
               state_q <= StIdle;
               done    <= 1'b0;
            end
            default: begin
               state_q <= StIdle;
               busy    <= 1'b0;
               arr_rst <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

`ifdef SYSTOLIC_FEEDER_ERR_EN
   // Set wins over a simultaneous clear.
   always_ff @(posedge clk) begin
      if (rst)                         err <= 1'b0;
      else if (busy && (wr_en || start)) err <= 1'b1;
      else if (err_clr)                err <= 1'b0;
   end
`endif

   assign out_west0  = west_q[0];
   assign out_west4  = west_q[1];
   assign out_west8  = west_q[2];
   assign out_west12 = west_q[3];
   assign out_north0 = north_q[0];
   assign out_north1 = north_q[1];
   assign out_north2 = north_q[2];
   assign out_north3 = north_q[3];

endmodule
